pipe_skid_buffer: RTL and testbench
===================================

// Module: pipe_skid_buffer
//
// PURPOSE
//   Two-entry valid/ready register slice on the input side of a registered compute stage
//   (e.g. the registered a&b cell and its hierarchy wrappers).
//   - Breaks the combinational ready path between producer and consumer.
//   - Sustains one transfer per cycle.
//   - Keeps the stage boundary at a flop, so timing.py sees a clean reg-to-reg path
//     through every level of hierarchy.
//
// PARAMETERS
//   WIDTH  8  payload width in bits
//
// PORTS
//   clk        in   1      clock, all flops on posedge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      upstream has data on in_data
//   in_data    in   WIDTH  upstream payload
//   in_ready   out  1      buffer accepts this cycle (registered)
//   out_valid  out  1      out_data is valid
//   out_data   out  WIDTH  payload to downstream stage (registered)
//   out_ready  in   1      downstream accepts this cycle
//   occupancy  out  2      entries held: 0, 1 or 2
//
// BEHAVIOUR
//   - Interface: single clock domain. Async active-high reset on every flop (posedge clk, posedge rst).
//   - Transfer rules:
//     - in_fire  = in_valid  & in_ready
//     - out_fire = out_valid & out_ready
//     - in_ready, out_valid and occupancy come straight from flops; no comb path from inputs.
//   - Storage: main register (drives out_data) and skid register.
//   - States (2-bit enum), decoded outputs:
//     - EMPTY: occupancy=0, out_valid=0, in_ready=1
//     - BUSY:  occupancy=1, out_valid=1, in_ready=1
//     - FULL:  occupancy=2, out_valid=1, in_ready=0
//   - Transitions:
//     - EMPTY, in_fire:             main<=in_data, -> BUSY
//     - BUSY,  in_fire & out_fire:  main<=in_data, stay BUSY
//     - BUSY,  in_fire only:        skid<=in_data, -> FULL
//     - BUSY,  out_fire only:       -> EMPTY (main keeps stale value)
//     - FULL,  out_fire:            main<=skid, -> BUSY
//     - FULL,  no out_fire:         hold both registers
//     - any other case:             hold state and registers
//   - Latency: in_fire in cycle N -> data on out_data with out_valid=1 in cycle N+1.
//   - Throughput: 1 word/cycle when out_ready stays high.
//   - Ordering: strict FIFO, no drop, no duplicate.
//   - Upstream rules:
//     - in_valid without in_ready is a legal stall; upstream holds in_data stable until accepted.
//     - in_data is ignored while in_ready=0.
//   - Downstream rules:
//     - out_valid never falls without out_fire.
//     - out_data is stable while out_valid & !out_ready.
//   - Reset (async, mid-operation included):
//     - state=EMPTY, in_ready=1, out_valid=0, occupancy=0, out_data=0, skid=0.
//     - Held data is discarded.
//     - First transfer possible on the first clock edge after rst deasserts.
//   - Simultaneous in_valid/out_ready in EMPTY: only in_fire occurs, since out_valid=0 (no bypass).
//
// STRUCTURE
//   - Shared package pipe_pkg: typedef enum logic [1:0] {SKID_EMPTY=0, SKID_BUSY=1, SKID_FULL=2}
//     skid_state_t. Reused by later pipeline slices and the bench.
//   - Single flat module, no sub-module.
//   - One always_ff for state plus main/skid registers.
//   - Outputs decoded from state; in_ready and out_valid kept as explicit flops.
//
// TESTING
//   - Reset: rst=1 mid-run with occupancy=2 -> same cycle: out_valid=0, in_ready=1, occupancy=0, out_data=0.
//   - Streaming: out_ready=1, in_valid=1, in_data=0x01..0x10 on 16 cycles -> out_data 0x01..0x10 one cycle
//     later, no bubbles, occupancy stays 1.
//   - Backpressure: out_ready=0, send 0xA1,0xA2,0xA3 -> accepts 0xA1,0xA2, in_ready=0 with occupancy=2.
//     Then out_ready=1 -> outputs 0xA1,0xA2,0xA3 in order.
//   - Simultaneous fire in BUSY: main=0x55, in_data=0x66, out_ready=1 -> 0x55 consumed,
//     next cycle out_data=0x66, occupancy=1.
//   - Drain from FULL with in_valid=0: out_ready=1 for 2 cycles -> occupancy 2->1->0, out_valid falls after
//     the second word.
//   - Random valid/ready for 10k cycles (WIDTH=8 and 32) against a scoreboard queue -> zero mismatches;
//     out_data stable whenever out_valid & !out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline register slices.
//
// Contents:
//   skid_state_t        - state encoding of the two-entry skid buffer
//   skid_occupancy()    - entries held in a given state
//   skid_in_ready()     - whether a given state can accept a word
//   skid_out_valid()    - whether a given state presents a word downstream
package pipe_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    localparam logic [1:0] SKID_OCC_EMPTY = 2'd0;
    localparam logic [1:0] SKID_OCC_BUSY  = 2'd1;
    localparam logic [1:0] SKID_OCC_FULL  = 2'd2;

    function automatic logic [1:0] skid_occupancy(input skid_state_t st);
        logic [1:0] occ;
        case (st)
            SKID_BUSY: occ = SKID_OCC_BUSY;
            SKID_FULL: occ = SKID_OCC_FULL;
            default:   occ = SKID_OCC_EMPTY;
        endcase
        return occ;
    endfunction

    function automatic logic skid_in_ready(input skid_state_t st);
        return (st != SKID_FULL);
    endfunction

    function automatic logic skid_out_valid(input skid_state_t st);
        return (st == SKID_BUSY) || (st == SKID_FULL);
    endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready register slice.
//
// Cuts the combinational ready path between producer and consumer while still
// sustaining one transfer per cycle. Every output comes straight from a flop.
//
// State table:
//   state      | meaning
//   SKID_EMPTY | nothing held; out_valid=0, in_ready=1, occupancy=0
//   SKID_BUSY  | one word in main; out_valid=1, in_ready=1, occupancy=1
//   SKID_FULL  | main and skid both held; out_valid=1, in_ready=0, occupancy=2
//
// Ports:
//   clk        clock, all flops on posedge
//   rst        asynchronous reset, active-high
//   in_valid   upstream has data on in_data
//   in_data    upstream payload
//   in_ready   buffer accepts this cycle (registered)
//   out_valid  out_data is valid (registered)
//   out_data   payload to the downstream stage (registered, from main)
//   out_ready  downstream accepts this cycle
//   occupancy  entries held: 0, 1 or 2 (registered)
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    skid_state_t      r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       r_occupancy;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    skid_state_t      w_state_nxt;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_fire;
    logic             w_out_fire;

    // Handshakes use the registered ready/valid, so nothing from the inputs
    // reaches an output combinationally.
    assign w_in_fire  = in_valid  & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;

        case (r_state)
            SKID_EMPTY: begin
                // out_valid is low here, so there is no bypass to consume
                if (w_in_fire) begin
                    w_main_nxt  = in_data;
                    w_state_nxt = SKID_BUSY;
                end
            end

            SKID_BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nxt = in_data;
                end else if (w_in_fire) begin
                    // main is stalled downstream; park the new word in skid
                    w_skid_nxt  = in_data;
                    w_state_nxt = SKID_FULL;
                end else if (w_out_fire) begin
                    // main keeps its stale value; out_valid hides it
                    w_state_nxt = SKID_EMPTY;
                end
            end

            SKID_FULL: begin
                // in_ready is low, so only the output side can move
                if (w_out_fire) begin
                    w_main_nxt  = r_skid;
                    w_state_nxt = SKID_BUSY;
                end
            end

            default: begin
                w_state_nxt = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SKID_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occupancy <= SKID_OCC_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            // decoded from the next state so the flops always agree with r_state
            r_in_ready  <= skid_in_ready(w_state_nxt);
            r_out_valid <= skid_out_valid(w_state_nxt);
            r_occupancy <= skid_occupancy(w_state_nxt);
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_occupancy;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
module tb_pipe_skid_buffer;
    import pipe_pkg::*;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [1:0]  occupancy;

    logic        w_in_valid;
    logic [31:0] w_in_data;
    logic        w_in_ready;
    logic        w_out_valid;
    logic [31:0] w_out_data;
    logic        w_out_ready;
    logic [1:0]  w_occupancy;

    int total = 0;
    int bad   = 0;

    pipe_skid_buffer #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    pipe_skid_buffer #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_data   (w_in_data),
        .in_ready  (w_in_ready),
        .out_valid (w_out_valid),
        .out_data  (w_out_data),
        .out_ready (w_out_ready),
        .occupancy (w_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic       ir;
        logic [1:0] occ;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [7:0] id, input logic ordy,
                       input logic ov, input logic [7:0] od, input logic ir, input logic [1:0] occ);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy;
        v.ov = ov; v.od = od; v.ir = ir; v.occ = occ;
        vecs.push_back(v);
    endtask

    task automatic chk_outs(input string tag, input logic ov, input logic [7:0] od,
                            input logic ir, input logic [1:0] occ);
        chk({tag, "_ov"},  {31'd0, out_valid}, {31'd0, ov});
        chk({tag, "_od"},  {24'd0, out_data},  {24'd0, od});
        chk({tag, "_ir"},  {31'd0, in_ready},  {31'd0, ir});
        chk({tag, "_occ"}, {30'd0, occupancy}, {30'd0, occ});
    endtask

    // random-phase scoreboards, index 0 = WIDTH 8, index 1 = WIDTH 32
    logic [31:0] sb0[$];
    logic [31:0] sb1[$];
    logic        pv_hold[2];
    logic [31:0] pv_data[2];

    task automatic rnd_check(input int k, input logic ov, input logic ir, input logic [1:0] occ,
                             input logic [31:0] od, input logic iv, input logic [31:0] idat,
                             input logic ordy);
        int          sz;
        logic [31:0] exp;
        sz = (k == 0) ? sb0.size() : sb1.size();
        chk($sformatf("rnd%0d_occ", k), {30'd0, occ}, sz);
        chk($sformatf("rnd%0d_ir", k), {31'd0, ir}, {31'd0, (sz < 2)});
        if (pv_hold[k]) begin
            chk($sformatf("rnd%0d_stable_ov", k), {31'd0, ov}, 32'd1);
            chk($sformatf("rnd%0d_stable_od", k), od, pv_data[k]);
        end
        if (ov && ordy) begin
            if (sz == 0) begin
                chk($sformatf("rnd%0d_spurious", k), {31'd0, ov}, 32'd0);
            end else begin
                exp = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                chk($sformatf("rnd%0d_data", k), od, exp);
            end
        end
        if (iv && ir) begin
            if (k == 0) sb0.push_back(idat);
            else        sb1.push_back(idat);
        end
        pv_hold[k] = ov && !ordy;
        pv_data[k] = od;
    endtask

    initial begin
        logic hold0, hold1;

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b0;
        w_in_valid  = 1'b0;
        w_in_data   = 32'h0;
        w_out_ready = 1'b0;

        #12;
        chk_outs("reset", 1'b0, 8'h00, 1'b1, 2'd0);
        rst = 1'b0;

        // streaming: one word per cycle, one cycle latency, occupancy stays 1
        for (int i = 1; i <= 16; i++) add(1, 8'(i), 1, 1, 8'(i), 1, 2'd1);
        add(0, 8'h00, 1, 0, 8'h10, 1, 2'd0);
        // backpressure
        add(1, 8'hA1, 0, 1, 8'hA1, 1, 2'd1);
        add(1, 8'hA2, 0, 1, 8'hA1, 0, 2'd2);
        add(1, 8'hA3, 0, 1, 8'hA1, 0, 2'd2);
        add(1, 8'hA3, 1, 1, 8'hA2, 1, 2'd1);
        add(1, 8'hA3, 1, 1, 8'hA3, 1, 2'd1);
        add(0, 8'h00, 0, 1, 8'hA3, 1, 2'd1);
        add(0, 8'h00, 1, 0, 8'hA3, 1, 2'd0);
        // simultaneous fire in BUSY
        add(1, 8'h55, 0, 1, 8'h55, 1, 2'd1);
        add(1, 8'h66, 1, 1, 8'h66, 1, 2'd1);
        add(0, 8'h00, 1, 0, 8'h66, 1, 2'd0);
        // EMPTY with in_valid and out_ready both high: no bypass
        add(1, 8'h77, 1, 1, 8'h77, 1, 2'd1);
        // drain from FULL with in_valid low
        add(1, 8'h88, 0, 1, 8'h77, 0, 2'd2);
        add(0, 8'h00, 1, 1, 8'h88, 1, 2'd1);
        add(0, 8'h00, 1, 0, 8'h88, 1, 2'd0);
        add(0, 8'h00, 1, 0, 8'h88, 1, 2'd0);

        foreach (vecs[i]) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].ir, vecs[i].occ);
        end

        // asynchronous reset while FULL
        in_valid = 1'b1; in_data = 8'h91; out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 8'h92;
        @(posedge clk); #1;
        chk_outs("prefill", 1'b1, 8'h91, 1'b0, 2'd2);
        #3;
        rst = 1'b1;
        #1;
        chk_outs("async_rst", 1'b0, 8'h00, 1'b1, 2'd0);
        #2;
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
        @(posedge clk); #1;
        chk_outs("post_rst_first", 1'b1, 8'h3C, 1'b1, 2'd1);
        // held data from before reset must not reappear
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk_outs("post_rst_drain", 1'b0, 8'h3C, 1'b1, 2'd0);
        out_ready = 1'b0;

        // random valid/ready against scoreboards, both widths
        pv_hold[0] = 1'b0; pv_hold[1] = 1'b0;
        pv_data[0] = '0;   pv_data[1] = '0;
        hold0 = 1'b0; hold1 = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!hold0) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom_range(0, 255));
            end
            out_ready = ($urandom_range(0, 1) != 0);
            if (!hold1) begin
                w_in_valid = ($urandom_range(0, 3) != 0);
                w_in_data  = $urandom;
            end
            w_out_ready = ($urandom_range(0, 1) != 0);

            rnd_check(0, out_valid, in_ready, occupancy, {24'd0, out_data},
                      in_valid, {24'd0, in_data}, out_ready);
            rnd_check(1, w_out_valid, w_in_ready, w_occupancy, w_out_data,
                      w_in_valid, w_in_data, w_out_ready);
            hold0 = in_valid && !in_ready;
            hold1 = w_in_valid && !w_in_ready;

            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
